// File: rtl/rx_pix_buf.sv
// rx_pix_buf -- packet-committing pixel FIFO between the GMII receiver and
// the video consumer.
//
// Words of a video packet are written speculatively behind wr_shadow and
// become readable only when the whole packet (exactly PKT_WORDS words)
// has arrived; a short, long or overflowing packet is rolled back.  A
// packet that starts while there is not room for a full packet is
// dropped outright.
//
// Ports
//   clk125       in   1   single clock, rising edge
//   sys_rst      in   1   asynchronous active-high reset
//   datain       in  29   {1'b?, x half, line[10:0], pixel[15:0]}
//   recv_en      in   1   datain valid
//   packet_en    in   1   high for the duration of a matched video packet
//   rd_en        in   1   read request
//   dout         out 29   read data (1-cycle latency)
//   dout_valid   out  1   dout holds a word popped in the previous cycle
//   empty        out  1   no committed words available
//   overflow     out  1   sticky: a write was lost because the FIFO was full
//   pkt_ok_cnt   out 16   committed packets (saturating)
//   pkt_drop_cnt out 16   dropped / rolled-back packets (saturating)
//
// Configuration
//   RX_PIX_BUF_STATS_EN  when defined, the packet counters are implemented;
//                        otherwise both counter outputs are tied to zero.

module rx_pix_buf #(
    parameter int ADDR_W    = 11,
    parameter int PKT_WORDS = 640
) (
    input  logic        clk125,
    input  logic        sys_rst,
    input  logic [28:0] datain,
    input  logic        recv_en,
    input  logic        packet_en,
    input  logic        rd_en,
    output logic [28:0] dout,
    output logic        dout_valid,
    output logic        empty,
    output logic        overflow,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_drop_cnt
);

    localparam int PTR_W  = ADDR_W + 1;
    localparam int FREE_W = ADDR_W + 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [FREE_W-1:0] DEPTH_C     = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [PTR_W-1:0]  FULL_C      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [FREE_W-1:0] PKT_WORDS_C = FREE_W'(PKT_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_DROP   = 2'd2,
        S_CLOSE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               pkt_en_d_r;
    logic               close_acc_r;
    logic               pkt_ovf_r;
    logic               overflow_r;
    logic [PTR_W-1:0]   wr_shadow_r, wr_commit_r, rd_ptr_r;
    logic [FREE_W-1:0]  word_cnt_r;
    logic [28:0]        dout_r;
    logic               dout_valid_r;
    logic [28:0]        mem [0:DEPTH-1];

    logic               rise_s, fall_s;
    logic [PTR_W-1:0]   used_s, shadow_used_s;
    logic [FREE_W-1:0]  free_s;
    logic               full_s, capture_s, wr_s, lost_s, rd_s, empty_s;
    logic               commit_s, rollback_s;

    assign rise_s        = packet_en & ~pkt_en_d_r;
    assign fall_s        = ~packet_en & pkt_en_d_r;
    // Pointer differences are taken at pointer width so wrap is modular.
    assign used_s        = wr_commit_r - rd_ptr_r;
    assign shadow_used_s = wr_shadow_r - rd_ptr_r;
    assign free_s        = DEPTH_C - {1'b0, used_s};
    assign full_s        = (shadow_used_s == FULL_C);
    assign empty_s       = (rd_ptr_r == wr_commit_r);
    assign capture_s     = recv_en && ((state_r == S_ACCEPT) ||
                                       ((state_r == S_CLOSE) && close_acc_r));
    assign wr_s          = capture_s && !full_s;
    assign lost_s        = capture_s && full_s;
    assign rd_s          = rd_en && !empty_s;
    // The CLOSE-cycle word still counts towards the packet length.
    assign commit_s      = (state_r == S_CLOSE) && close_acc_r && !pkt_ovf_r && !lost_s &&
                           ((word_cnt_r + FREE_W'(wr_s)) == PKT_WORDS_C);
    assign rollback_s    = (state_r == S_CLOSE) && close_acc_r && !commit_s;

    // Next-state logic for the packet FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (rise_s) begin
                    if (free_s >= PKT_WORDS_C) begin
                        state_s = S_ACCEPT;
                    end else begin
                        state_s = S_DROP;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (fall_s) begin
                    state_s = S_CLOSE;
                end else begin
                    state_s = S_ACCEPT;
                end
            end
            S_DROP: begin
                if (fall_s) begin
                    state_s = S_CLOSE;
                end else begin
                    state_s = S_DROP;
                end
            end
            S_CLOSE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM, pointers, read port and overflow flag
    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            state_r      <= S_IDLE;
            // Reset to 1 so a packet already in flight at release is not
            // mistaken for a new packet start.
            pkt_en_d_r   <= 1'b1;
            close_acc_r  <= 1'b0;
            pkt_ovf_r    <= 1'b0;
            overflow_r   <= 1'b0;
            wr_shadow_r  <= {PTR_W{1'b0}};
            wr_commit_r  <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            word_cnt_r   <= {FREE_W{1'b0}};
            dout_r       <= 29'd0;
            dout_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pkt_en_d_r <= packet_en;

            if (state_r == S_ACCEPT) begin
                close_acc_r <= 1'b1;
            end else if (state_r == S_DROP) begin
                close_acc_r <= 1'b0;
            end

            if ((state_r == S_IDLE) && (state_s == S_ACCEPT)) begin
                word_cnt_r <= {FREE_W{1'b0}};
                pkt_ovf_r  <= 1'b0;
            end else begin
                if (wr_s) begin
                    word_cnt_r <= word_cnt_r + {{(FREE_W-1){1'b0}}, 1'b1};
                end
                if (lost_s) begin
                    pkt_ovf_r <= 1'b1;
                end
            end

            if (lost_s) begin
                overflow_r <= 1'b1;
            end

            // Rollback takes priority over a CLOSE-cycle write.
            if (rollback_s) begin
                wr_shadow_r <= wr_commit_r;
            end else if (wr_s) begin
                wr_shadow_r <= wr_shadow_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end

            if (commit_s) begin
                wr_commit_r <= wr_shadow_r + PTR_W'(wr_s);
            end

            if (rd_s) begin
                dout_r   <= mem[rd_ptr_r[ADDR_W-1:0]];
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            dout_valid_r <= rd_s;
        end
    end

    // Packet storage; contents survive reset
    always_ff @(posedge clk125) begin
        if (wr_s) begin
            mem[wr_shadow_r[ADDR_W-1:0]] <= datain;
        end
    end

`ifdef RX_PIX_BUF_STATS_EN
    logic [15:0] ok_cnt_r, drop_cnt_r;
    logic        drop_inc_s;

    // Every CLOSE that does not commit is a dropped or rolled-back packet.
    assign drop_inc_s = (state_r == S_CLOSE) && !commit_s;

    // Saturating packet statistics
    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            ok_cnt_r   <= 16'h0000;
            drop_cnt_r <= 16'h0000;
        end else begin
            if (commit_s && (ok_cnt_r != 16'hFFFF)) begin
                ok_cnt_r <= ok_cnt_r + 16'h0001;
            end
            if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end

    assign pkt_ok_cnt   = ok_cnt_r;
    assign pkt_drop_cnt = drop_cnt_r;
`else
    assign pkt_ok_cnt   = 16'h0000;
    assign pkt_drop_cnt = 16'h0000;
`endif

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign empty      = empty_s;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_rx_pix_buf.sv
// Self-checking bench for rx_pix_buf.  A packet-level model (queue of
// committed words, accept/commit decided from packet length and free
// space) predicts every output; a compare process checks it each cycle.
module tb_rx_pix_buf;

    localparam int DEPTH = 2048;
    localparam int PKT   = 640;

    logic        clk125 = 1'b0;
    logic        sys_rst;
    logic [28:0] datain;
    logic        recv_en, packet_en, rd_en;
    logic [28:0] dout;
    logic        dout_valid, empty, overflow;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt;

    rx_pix_buf #(.ADDR_W(11), .PKT_WORDS(640)) dut (
        .clk125(clk125), .sys_rst(sys_rst), .datain(datain), .recv_en(recv_en),
        .packet_en(packet_en), .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
        .empty(empty), .overflow(overflow), .pkt_ok_cnt(pkt_ok_cnt),
        .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #5 clk125 = ~clk125;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_reads = 0;
    bit          chk_on = 1'b0;
    bit          rd_on = 1'b0;
    logic [28:0] exp_q[$];
    logic [28:0] exp_dout = 29'd0;
    logic [28:0] pend_word;
    bit          rd_pend = 1'b0;
    bit          exp_ovf = 1'b0;
    int          exp_ok = 0;
    int          exp_drop = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] stat(input int v);
`ifdef RX_PIX_BUF_STATS_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    function automatic logic [28:0] word(input int id, input int i);
        logic [10:0] line_v;
        logic [15:0] pix_v;
        line_v = id[10:0];
        pix_v  = 16'(i * 3 + id);
        return {1'b0, (i >= 320) ? 1'b1 : 1'b0, line_v, pix_v};
    endfunction

    // One clock: drive inputs, return 1 ns after the edge that samples them.
    task automatic cyc(input logic pen, input logic rv, input logic [28:0] d);
        packet_en = pen;
        recv_en   = rv;
        datain    = d;
        rd_en     = rd_on;
        @(posedge clk125);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 29'd0);
    endtask

    // Send a packet of n words; late puts the final word one cycle after
    // packet_en falls.  The model decides accept/commit from its own queue.
    task automatic send_pkt(input int n, input bit late, input bit pin_close, input int id);
        int          free_w;
        int          cap;
        bit          acc;
        bit          lost;
        logic [28:0] buf_q[$];
        free_w = DEPTH - exp_q.size();
        acc    = (free_w >= PKT);
        cap    = 0;
        lost   = 1'b0;
        cyc(1'b1, 1'b0, 29'd0);
        for (int i = 0; i < n; i++) begin
            if (late && (i == n - 1)) begin
                cyc(1'b0, 1'b0, 29'd0);
                cyc(1'b0, 1'b1, word(id, i));
            end else begin
                cyc(1'b1, 1'b1, word(id, i));
            end
            if (acc) begin
                if (cap < free_w) begin
                    buf_q.push_back(word(id, i));
                    cap++;
                end else begin
                    lost    = 1'b1;
                    exp_ovf = 1'b1;
                end
            end
        end
        if (!late) begin
            cyc(1'b0, 1'b0, 29'd0);
            if (pin_close) chk("empty_in_close", 32'(empty), 32'd1);
            cyc(1'b0, 1'b0, 29'd0);
        end
        if (acc && !lost && (cap == PKT)) begin
            foreach (buf_q[k]) exp_q.push_back(buf_q[k]);
            exp_ok++;
        end else begin
            exp_drop++;
        end
        if (pin_close) chk("empty_after_close", 32'(empty), 32'd0);
    endtask

    task automatic read_n(input int n);
        rd_on = 1'b1;
        repeat (n) idle();
        rd_on = 1'b0;
        idle();
    endtask

    task automatic drain();
        int k;
        rd_on = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || rd_pend) && k < 4000) begin
            idle();
            k++;
        end
        if (k >= 4000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        idle();
        rd_on = 1'b0;
        idle();
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    // Compare process: outputs are sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk125);
            if (sys_rst) begin
                rd_pend = 1'b0;
            end else if (chk_on) begin
                chk("dout_valid", 32'(dout_valid), 32'(rd_pend));
                if (rd_pend) begin
                    exp_dout = pend_word;
                    n_reads++;
                end
                chk("dout", 32'(dout), 32'(exp_dout));
                chk("empty", 32'(empty), 32'(exp_q.size() == 0));
                chk("overflow", 32'(overflow), 32'(exp_ovf));
                chk("pkt_ok_cnt", 32'(pkt_ok_cnt), stat(exp_ok));
                chk("pkt_drop_cnt", 32'(pkt_drop_cnt), stat(exp_drop));
                rd_pend = rd_en && (exp_q.size() != 0);
                if (rd_pend) pend_word = exp_q.pop_front();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0;
        sys_rst = 1'b1; packet_en = 1'b0; recv_en = 1'b0; rd_en = 1'b0; datain = 29'd0;
        repeat (3) @(posedge clk125);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ok", 32'(pkt_ok_cnt), 32'd0);
        chk("rst_drop", 32'(pkt_drop_cnt), 32'd0);
        sys_rst = 1'b0;
        chk_on  = 1'b1;
        idle(); idle();

        // Full packet into empty FIFO, single read pins the first word.
        send_pkt(640, 1'b0, 1'b1, 1);
        chk("ok_after_first", 32'(pkt_ok_cnt), stat(1));
        rd_on = 1'b1; idle(); rd_on = 1'b0; idle();
        chk("first_word", 32'(dout), 32'h0001_0001);
        drain();

        // Truncated packet: nothing readable, counted as drop.
        send_pkt(500, 1'b0, 1'b0, 2);
        idle();
        chk("trunc_empty", 32'(empty), 32'd1);
        chk("trunc_drop", 32'(pkt_drop_cnt), stat(1));

        // Last word one cycle after packet_en falls.
        send_pkt(640, 1'b1, 1'b0, 3);
        idle();
        chk("late_ok", 32'(pkt_ok_cnt), stat(2));
        drain();

        // Fill to 1500 committed words, then a packet must be dropped.
        send_pkt(640, 1'b0, 1'b0, 4);
        send_pkt(640, 1'b0, 1'b0, 5);
        send_pkt(640, 1'b0, 1'b0, 6);
        read_n(420);
        send_pkt(640, 1'b0, 1'b0, 7);
        idle();
        chk("full_drop", 32'(pkt_drop_cnt), stat(2));
        chk("full_not_empty", 32'(empty), 32'd0);
        rd0 = n_reads;
        drain();
        chk("full_remaining", 32'(n_reads - rd0), 32'd1500);

        // 1400 held, 700-word packet overflows and rolls back.
        send_pkt(640, 1'b0, 1'b0, 8);
        send_pkt(640, 1'b0, 1'b0, 9);
        send_pkt(640, 1'b0, 1'b0, 10);
        read_n(520);
        send_pkt(700, 1'b0, 1'b0, 11);
        idle();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(pkt_drop_cnt), stat(3));
        drain();

        // Continuous reads across the address wrap with four packets.
        rd_on = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_pkt(640, 1'b0, 1'b0, 20 + p);
            idle();
        end
        drain();
        chk("wrap_ok", 32'(pkt_ok_cnt), stat(12));
        chk("wrap_empty", 32'(empty), 32'd1);

        // Reset at word 300 with a committed packet already buffered.
        send_pkt(640, 1'b0, 1'b0, 30);
        cyc(1'b1, 1'b0, 29'd0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, word(31, i));
        #2;
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_ok", 32'(pkt_ok_cnt), 32'd0);
        chk("mid_rst_drop", 32'(pkt_drop_cnt), 32'd0);
        exp_q.delete();
        exp_dout = 29'd0;
        exp_ovf  = 1'b0;
        exp_ok   = 0;
        exp_drop = 0;
        @(posedge clk125);
        #1;
        cyc(1'b1, 1'b1, word(31, 300));
        sys_rst = 1'b0;
        for (int i = 301; i < 320; i++) cyc(1'b1, 1'b1, word(31, i));
        idle(); idle(); idle();
        chk("post_rst_empty", 32'(empty), 32'd1);
        send_pkt(640, 1'b0, 1'b0, 32);
        idle();
        chk("post_rst_ok", 32'(pkt_ok_cnt), stat(1));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
